// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM-stage controller.
//   Runs the data-memory req/ack handshake for the access held in EX/MEM and
//   stalls the upstream pipeline while it is outstanding. It also resolves
//   branch/jump PC selection and holds the MEM/WB pipeline register.
// Optional feature macro: MISALIGN_TRAP_EN (misaligned-access trap).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   ex_*                     EX/MEM pipeline register outputs
//   dmem_req/we/addr/wdata   data-memory request (combinational)
//   dmem_rdata/ack           data-memory response
//   stall                    freezes PC, IF/ID, ID/EX, EX/MEM (combinational)
//   pc_src/jump_taken/target_pc  PC selection (combinational)
//   wb_*                     MEM/WB register outputs
//   stall_cycles             saturating stalled-cycle counter
//   misalign_trap/addr       misaligned-access trap pulse and address
module mem_stage_ctrl #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] ex_result,
  input  logic [DATA_W-1:0] ex_rd2,
  input  logic [DATA_W-1:0] ex_pc,
  input  logic [DATA_W-1:0] ex_or_pc,
  input  logic [REG_W-1:0]  ex_wn,
  input  logic              ex_reg_write,
  input  logic              ex_mem_to_reg,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              ex_branch,
  input  logic              ex_zero,
  input  logic              ex_jump,
  input  logic              ex_jal,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic              stall,
  output logic              pc_src,
  output logic              jump_taken,
  output logic [DATA_W-1:0] target_pc,
  output logic              wb_reg_write,
  output logic              wb_mem_to_reg,
  output logic              wb_jal,
  output logic [DATA_W-1:0] wb_read_data,
  output logic [DATA_W-1:0] wb_result,
  output logic [DATA_W-1:0] wb_link_pc,
  output logic [REG_W-1:0]  wb_wn,
  output logic [31:0]       stall_cycles,
  output logic              misalign_trap,
  output logic [DATA_W-1:0] misalign_addr
);

  localparam int unsigned CNT_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t state;
  state_t state_nx;

  logic access;
  logic misaligned;
  logic issue;

  assign access = ex_mem_read | ex_mem_write;

`ifdef MISALIGN_TRAP_EN
  assign misaligned = access & (ex_result[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // A misaligned access never reaches memory.
  assign issue = access & ~misaligned;

  // Address and data are stable across WAIT because EX/MEM is frozen.
  assign dmem_we    = dmem_req & ex_mem_write;
  assign dmem_addr  = {ex_result[DATA_W-1:2], 2'b00};
  assign dmem_wdata = ex_rd2;

  // PC selection is deliberately not gated by stall.
  assign pc_src     = ex_branch & ex_zero;
  assign jump_taken = ex_jump;
  assign target_pc  = ex_pc;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state and handshake outputs; no stall in the ack cycle.
  always_comb begin
    state_nx = state;
    dmem_req = 1'b0;
    stall    = 1'b0;
    case (state)
      IDLE: begin
        if (issue) begin
          dmem_req = 1'b1;
          if (!dmem_ack) begin
            stall    = 1'b1;
            state_nx = WAIT;
          end
        end
      end
      WAIT: begin
        if (issue) begin
          dmem_req = 1'b1;
          if (dmem_ack) state_nx = IDLE;
          else          stall    = 1'b1;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // MEM/WB register: bubble while stalled, otherwise capture EX/MEM.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_reg_write  <= 1'b0;
      wb_mem_to_reg <= 1'b0;
      wb_jal        <= 1'b0;
      wb_read_data  <= '0;
      wb_result     <= '0;
      wb_link_pc    <= '0;
      wb_wn         <= '0;
    end else if (stall) begin
      wb_reg_write <= 1'b0;
      wb_jal       <= 1'b0;
    end else begin
      wb_reg_write  <= ex_reg_write & ~misaligned;
      wb_mem_to_reg <= ex_mem_to_reg;
      wb_jal        <= ex_jal;
      wb_read_data  <= ex_mem_read ? dmem_rdata : '0;
      wb_result     <= ex_result;
      wb_link_pc    <= ex_or_pc;
      wb_wn         <= ex_wn;
    end
  end

  // Saturating stalled-cycle counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (stall && (stall_cycles != {CNT_W{1'b1}})) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

`ifdef MISALIGN_TRAP_EN
  // One-cycle trap pulse; address held until the next trap.
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_trap <= 1'b0;
      misalign_addr <= '0;
    end else begin
      misalign_trap <= misaligned;
      if (misaligned) misalign_addr <= ex_result;
    end
  end
`else
  assign misalign_trap = 1'b0;
  assign misalign_addr = '0;
`endif

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
MEM-stage controller that consumes the EX/MEM pipeline register outputs. It runs the data-memory request/acknowledge handshake and stalls the upstream pipeline while an access is outstanding. It resolves branch and jump for PC selection and contains the MEM/WB pipeline register that feeds the write-back stage.

Parameters:
DATA_W, 32, datapath and address width
REG_W, 5, register-number width

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
ex_result  in  DATA_W  ALU result; memory address for loads and stores
ex_rd2  in  DATA_W  store data
ex_pc  in  DATA_W  branch/jump target PC
ex_or_pc  in  DATA_W  return address (PC+4) for jal
ex_wn  in  REG_W  destination register
ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write, ex_branch, ex_zero, ex_jump, ex_jal  in  1 each  control bits
dmem_req  out  1  access request
dmem_we  out  1  1=write, 0=read
dmem_addr  out  DATA_W  word address
dmem_wdata  out  DATA_W  store data
dmem_rdata  in  DATA_W  load data; valid when dmem_ack=1
dmem_ack  in  1  access complete this cycle
stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM
pc_src  out  1  take branch (ex_branch & ex_zero)
jump_taken  out  1  = ex_jump
target_pc  out  DATA_W  = ex_pc
wb_reg_write, wb_mem_to_reg, wb_jal  out  1 each  MEM/WB control
wb_read_data, wb_result, wb_link_pc  out  DATA_W  MEM/WB data
wb_wn  out  REG_W  MEM/WB destination register
stall_cycles  out  32  saturating count of stalled cycles
misalign_trap  out  1  see Optional Feature
misalign_addr  out  DATA_W  see Optional Feature

Behaviour:
- access = ex_mem_read | ex_mem_write. If both are set, the access is a write (dmem_we=1).
- FSM states IDLE and WAIT.
  - IDLE: if access, dmem_req=1 combinationally. If dmem_ack=1 in the same cycle (zero-wait), stay in IDLE. Otherwise go to WAIT.
  - WAIT: dmem_req=1 held. dmem_addr, dmem_we and dmem_wdata are stable because EX/MEM is frozen. On dmem_ack=1, return to IDLE.
- stall = access & ~dmem_ack, in either state. There is no stall in the ack cycle, so the upstream pipeline advances on that edge and the access is never reissued.
- dmem_ack is ignored when dmem_req=0.
- dmem_addr = {ex_result[DATA_W-1:2], 2'b00}. dmem_wdata = ex_rd2.
- MEM/WB register, updated every posedge:
  - If stall=1, insert a bubble: wb_reg_write=0 and wb_jal=0; the other fields are don't-care, implement as hold.
  - Otherwise capture ex_* into wb_*. wb_read_data = dmem_rdata when ex_mem_read, else 0.
  - MEM/WB latency is 1 cycle after the ack cycle.
- pc_src, jump_taken and target_pc are combinational from the EX/MEM inputs and are not gated by stall.
- stall_cycles increments once per cycle with stall=1 and saturates at 0xFFFFFFFF.
- Reset: FSM to IDLE. All wb_* outputs are 0, including all REG_W bits of wb_wn. stall_cycles=0, misalign_trap=0, misalign_addr=0. Reset during WAIT drops dmem_req on the next cycle; an ack arriving after reset is ignored.

Optional Feature:
MISALIGN_TRAP_EN
- Defined: an access with ex_result[1:0]!=0 is treated as misaligned.
  - No dmem_req and no stall.
  - The MEM/WB entry is captured with wb_reg_write=0.
  - Next cycle, misalign_trap=1 for exactly one cycle and misalign_addr=ex_result, held until the next trap or reset.
- Undefined: the low address bits are silently dropped, and misalign_trap and misalign_addr are tied to 0.

Test Plan:
1. Zero-wait load: ex_mem_read=1, ex_result=0x100, dmem_ack=1 in the same cycle, dmem_rdata=0xDEADBEEF, ex_wn=5 -> stall stays 0; next cycle wb_read_data=0xDEADBEEF, wb_wn=5, wb_reg_write=1.
2. Store with 3 wait states: ex_mem_write=1, ex_result=0x40, ex_rd2=0x1234, ack in the 4th cycle -> dmem_req=1 and dmem_we=1 for 4 cycles; stall=1 for 3 cycles; stall_cycles=3; wb_reg_write=0 during the stall.
3. Branch: ex_branch=1, ex_zero=1, ex_pc=0x200 -> pc_src=1 and target_pc=0x200 in the same cycle. With ex_zero=0 -> pc_src=0.
4. jal: ex_jal=1, ex_or_pc=0x84, ex_wn=31 -> next cycle wb_jal=1, wb_link_pc=0x84, wb_wn=31.
5. Reset mid-WAIT: rst=1 during the 2nd wait cycle, then ack -> dmem_req=0, all wb_*=0, stall_cycles=0; the late ack causes no wb_* update.
6. (MISALIGN_TRAP_EN) load at 0x102 -> no dmem_req, stall=0; next cycle misalign_trap=1 and misalign_addr=0x102, then misalign_trap=0.
